// File: rtl/non_hwt_pkg.sv
// Shared types, widths and the golden cell function for the scan controller.
package non_hwt_pkg;

  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned VEC_W   = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned SET_W   = 4;

  localparam logic [NUM_VEC-1:0] GOLDEN_SIG_DEF = 16'hF800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reference cell: vec = {D, C, B, A}, Y = D & ((A & B) | C).
  function automatic logic golden_y(input logic [VEC_W-1:0] v);
    return v[3] & ((v[0] & v[1]) | v[2]);
  endfunction

endpackage

// File: rtl/non_hwt_resp_checker.sv
// Response checker: captures the sampled cell output per vector and tracks
// mismatches against the golden signature.
//   clk, rst       : clock, synchronous active-high reset
//   clear          : wipes results when a new scan is accepted
//   sample_en      : this edge samples dut_y for vector vec
//   vec, dut_y     : current vector and cell output
//   result_sig     : captured response, bit v = dut_y for vector v
//   mismatch_cnt   : number of mismatching vectors
//   fail_seen      : at least one mismatch
//   first_fail     : lowest-index mismatching vector
//   mismatch_c     : combinational, current sample mismatches
module non_hwt_resp_checker
  import non_hwt_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] GOLDEN_SIG = GOLDEN_SIG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               sample_en,
  input  logic [VEC_W-1:0]   vec,
  input  logic               dut_y,
  output logic [NUM_VEC-1:0] result_sig,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic               fail_seen,
  output logic [VEC_W-1:0]   first_fail,
  output logic               mismatch_c
);

  assign mismatch_c = sample_en && (dut_y != GOLDEN_SIG[vec]);

  // Vectors are visited in ascending order, so the first mismatch is the lowest.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      result_sig   <= '0;
      mismatch_cnt <= '0;
      fail_seen    <= 1'b0;
      first_fail   <= '0;
    end else if (sample_en) begin
      result_sig[vec] <= dut_y;
      if (mismatch_c) begin
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!fail_seen) begin
          first_fail <= vec;
          fail_seen  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/non_hwt_scan_ctrl.sv
// Self-test sequencer for the 4-input logic cell: walks all 16 input vectors,
// holds each for SETTLE_CYCLES+1 cycles, samples the cell output and reports
// signature, mismatch count, first failing vector and pass/abort status.
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : launch a scan from IDLE / terminate a scan in progress
//   dut_a..dut_d    : cell inputs, straight from the vector register
//   dut_y           : cell output
//   busy, done      : scanning / one-cycle end-of-scan pulse
//   aborted, pass   : last scan status
//   result_sig, mismatch_cnt, fail_seen, first_fail : response results
module non_hwt_scan_ctrl
  import non_hwt_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] GOLDEN_SIG    = GOLDEN_SIG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               dut_a,
  output logic               dut_b,
  output logic               dut_c,
  output logic               dut_d,
  input  logic               dut_y,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [NUM_VEC-1:0] result_sig,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic               fail_seen,
  output logic [VEC_W-1:0]   first_fail,
  output logic               pass
);

  localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VEC - 1);
  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CYCLES);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q;
  logic [SET_W-1:0]   settle_q;
  logic               start_acc_c;
  logic               settle_end_c;
  logic               sample_en_c;
  logic               mismatch_c;

  // Cell inputs come only from the vector register: glitch-free.
  assign dut_a = vec_q[0];
  assign dut_b = vec_q[1];
  assign dut_c = vec_q[2];
  assign dut_d = vec_q[3];

  // Next-state logic; abort outranks the sample at the same edge.
  always_comb begin
    state_d      = state_q;
    start_acc_c  = 1'b0;
    settle_end_c = (settle_q == SETTLE_MAX);
    sample_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc_c = 1'b1;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (settle_end_c) begin
          sample_en_c = 1'b1;
          if (vec_q == LAST_VEC) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Vector and settle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q    <= '0;
      settle_q <= '0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (!abort) begin
            if (!settle_end_c) begin
              settle_q <= settle_q + SET_W'(1);
            end else begin
              settle_q <= '0;
              if (vec_q != LAST_VEC) vec_q <= vec_q + VEC_W'(1);
            end
          end
        end
        default: begin
          vec_q    <= '0;
          settle_q <= '0;
        end
      endcase
    end
  end

  // Registered status outputs; pass folds in the final sample's mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      pass    <= 1'b0;
    end else begin
      busy <= (state_d == ST_SCAN);
      done <= (state_d == ST_DONE);
      if (start_acc_c) begin
        aborted <= 1'b0;
        pass    <= 1'b0;
      end else if (state_q == ST_SCAN && state_d == ST_DONE) begin
        aborted <= abort;
        pass    <= !abort && (mismatch_cnt == '0) && !mismatch_c;
      end
    end
  end

  non_hwt_resp_checker #(
    .GOLDEN_SIG (GOLDEN_SIG)
  ) u_checker (
    .clk          (clk),
    .rst          (rst),
    .clear        (start_acc_c),
    .sample_en    (sample_en_c),
    .vec          (vec_q),
    .dut_y        (dut_y),
    .result_sig   (result_sig),
    .mismatch_cnt (mismatch_cnt),
    .fail_seen    (fail_seen),
    .first_fail   (first_fail),
    .mismatch_c   (mismatch_c)
  );

endmodule

// File: tb/tb_non_hwt_scan_ctrl.sv
// Bench for non_hwt_scan_ctrl: two instances (settle 2 and settle 0) each
// driving a cell model; expected scan results are queued at stimulus time
// and checked by per-instance monitors on every done pulse.
module tb_non_hwt_scan_ctrl;
  import non_hwt_pkg::*;

  typedef struct {
    logic [15:0] sig;
    int          cnt;
    logic        fs;
    int          ff;
    logic        pass;
    logic        aborted;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start0, abort0, start1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Instance 0: default settle of 2.
  logic        a0, b0, c0, d0, y0, busy0, done0, ab0, fs0, pass0;
  logic [15:0] sig0;
  logic [4:0]  cnt0;
  logic [3:0]  ff0;

  // Instance 1: settle of 0, golden cell only.
  logic        a1, b1, c1, d1, y1, busy1, done1, ab1, fs1, pass1;
  logic [15:0] sig1;
  logic [4:0]  cnt1;
  logic [3:0]  ff1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell models. mode: 0 golden, 1 stuck-at-0, 2 trojan on vector 7, 3 inverted.
  always_comb begin
    logic [3:0] v;
    v = {d0, c0, b0, a0};
    case (mode)
      1:       y0 = 1'b0;
      2:       y0 = golden_y(v) ^ (v == 4'd7);
      3:       y0 = ~golden_y(v);
      default: y0 = golden_y(v);
    endcase
  end
  assign y1 = golden_y({d1, c1, b1, a1});

  non_hwt_scan_ctrl #(.SETTLE_CYCLES(2), .GOLDEN_SIG(16'hF800)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_d(d0), .dut_y(y0),
    .busy(busy0), .done(done0), .aborted(ab0), .result_sig(sig0),
    .mismatch_cnt(cnt0), .fail_seen(fs0), .first_fail(ff0), .pass(pass0)
  );

  non_hwt_scan_ctrl #(.SETTLE_CYCLES(0), .GOLDEN_SIG(16'hF800)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_d(d1), .dut_y(y1),
    .busy(busy1), .done(done1), .aborted(ab1), .result_sig(sig1),
    .mismatch_cnt(cnt1), .fail_seen(fs1), .first_fail(ff1), .pass(pass1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [15:0] sig,
                         input logic [4:0] cnt, input logic fs, input logic [3:0] ff,
                         input logic pass, input logic ab);
    chk({tag, "_done_cycle"}, cyc, e.cyc);
    chk({tag, "_result_sig"}, int'(sig), int'(e.sig));
    chk({tag, "_mismatch_cnt"}, int'(cnt), e.cnt);
    chk({tag, "_fail_seen"}, int'(fs), int'(e.fs));
    if (e.fs) chk({tag, "_first_fail"}, int'(ff), e.ff);
    chk({tag, "_pass"}, int'(pass), int'(e.pass));
    chk({tag, "_aborted"}, int'(ab), int'(e.aborted));
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        compare("dut0", e, sig0, cnt0, fs0, ff0, pass0, ab0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        compare("dut1", e, sig1, cnt1, fs1, ff1, pass1, ab1);
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pulse start0 for one edge; k is the accepting edge, returns at cycle k.
  task automatic start_pulse(output int k);
    @(negedge clk);
    start0 = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic push0(input logic [15:0] sig, input int cnt, input logic fs,
                       input int ff, input logic pass, input logic ab, input int c);
    exp_t e;
    e.sig = sig; e.cnt = cnt; e.fs = fs; e.ff = ff;
    e.pass = pass; e.aborted = ab; e.cyc = c;
    q0.push_back(e);
  endtask

  task automatic drain0(input string tag, input int t);
    wait_cyc(t);
    chk({tag, "_queue_drained"}, q0.size(), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_sig", int'(sig0), 0);
    chk("rst_cnt", int'(cnt0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_vec", int'({d0, c0, b0, a0}), 0);

    // Golden cell: vectors step every 3 cycles, done after edge k+48.
    mode = 0;
    start_pulse(k);
    push0(16'hF800, 0, 1'b0, 0, 1'b1, 1'b0, k + 48);
    for (int j = 0; j < 48; j++) begin
      chk("golden_vec", int'({d0, c0, b0, a0}), j / 3);
      chk("golden_busy", int'(busy0), 1);
      @(negedge clk);
    end
    drain0("golden", k + 52);
    chk("golden_idle_busy", int'(busy0), 0);
    chk("golden_idle_vec", int'({d0, c0, b0, a0}), 0);

    // Stuck-at-0 output.
    mode = 1;
    start_pulse(k);
    push0(16'h0000, 5, 1'b1, 11, 1'b0, 1'b0, k + 48);
    drain0("stuck0", k + 52);

    // Trojan flips vector 7 only.
    mode = 2;
    start_pulse(k);
    push0(16'hF880, 1, 1'b1, 7, 1'b0, 1'b0, k + 48);
    drain0("trojan", k + 52);

    // Inverted cell, abort during settle of vector 5 (vector 5 never sampled).
    mode = 3;
    start_pulse(k);
    push0(16'h001F, 5, 1'b1, 0, 1'b0, 1'b1, k + 16);
    wait_cyc(k + 15);
    chk("abort_pre_vec", int'({d0, c0, b0, a0}), 5);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    drain0("abort", k + 20);
    chk("abort_sig_hold", int'(sig0), 16'h001F);

    // Mid-scan start re-pulse is ignored, then reset at vector 9.
    mode = 0;
    start_pulse(k);
    wait_cyc(k + 10);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_cyc(k + 27);
    chk("repulse_vec9", int'({d0, c0, b0, a0}), 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_sig", int'(sig0), 0);
    chk("midrst_cnt", int'(cnt0), 0);
    chk("midrst_fs", int'(fs0), 0);
    chk("midrst_ff", int'(ff0), 0);
    chk("midrst_vec", int'({d0, c0, b0, a0}), 0);
    chk("midrst_pass_ab", int'({pass0, ab0}), 0);
    drain0("midrst_nodone", k + 60);
    start_pulse(k);
    push0(16'hF800, 0, 1'b0, 0, 1'b1, 1'b0, k + 48);
    drain0("post_rst", k + 52);

    // Settle 0 with start held: done every 18 cycles, three scans.
    @(negedge clk);
    start1 = 1'b1;
    k = cyc + 1;
    for (int s = 0; s < 3; s++) begin
      exp_t e;
      e.sig = 16'hF800; e.cnt = 0; e.fs = 1'b0; e.ff = 0;
      e.pass = 1'b1; e.aborted = 1'b0; e.cyc = k + 16 + 18 * s;
      q1.push_back(e);
    end
    wait_cyc(k + 37);
    start1 = 1'b0;
    wait_cyc(k + 60);
    chk("s0_queue_drained", q1.size(), 0);
    chk("s0_idle_busy", int'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/non_hwt_scan_ctrl.md
Name: non_hwt_scan_ctrl

Overview:
- Sequencer that drives the trojan-free 4-input logic cell through all 16 input vectors.
- Each vector is held for a programmable settle time, then the cell output is sampled and compared against the golden function Y = D & ((A & B) | C).
- Reports a 16-bit response signature, a mismatch count and the first failing vector.
- Sits beside the combinational cell as its self-test and HWT-detection controller; power pins are added at synthesis, and the RTL has none.

Parameters:
- SETTLE_CYCLES, 2: extra cycles each vector is held before `dut_y` is sampled. Legal range 0..15.
- GOLDEN_SIG, 16'hF800: expected response signature; bit v is the golden Y for vector v.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  level; accepted only in IDLE
- abort  input  1  level; terminates a scan in progress
- dut_a  output  1  cell input A = vec[0]
- dut_b  output  1  cell input B = vec[1]
- dut_c  output  1  cell input C = vec[2]
- dut_d  output  1  cell input D = vec[3]
- dut_y  input  1  cell output, sampled at end of settle window
- busy  output  1  high in SCAN
- done  output  1  one-cycle pulse when a full or aborted scan ends
- aborted  output  1  sticky; last scan was aborted
- result_sig  output  16  captured response, bit v = sampled `dut_y` for vector v
- mismatch_cnt  output  5  number of vectors with `dut_y` != golden (0..16)
- fail_seen  output  1  at least one mismatch in last scan
- first_fail  output  4  lowest-index failing vector; valid when `fail_seen` = 1
- pass  output  1  last scan completed, not aborted, `mismatch_cnt` = 0

Behaviour:
- Reset (`rst` = 1 at an edge), from any state:
  - state = IDLE, vec = 0, settle = 0.
  - `result_sig` = 0, `mismatch_cnt` = 0, `fail_seen` = 0, `first_fail` = 0, `pass` = 0, `aborted` = 0, `done` = 0, `busy` = 0.
  - `dut_a`..`dut_d` = 0.
  - Reset mid-scan discards all partial results.
- `dut_*` are driven from the registered vec only: glitch-free, no combinational path from inputs.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `start` = 1 at edge k -> SCAN, vec = 0, settle = 0.
  - Clears `result_sig`, `mismatch_cnt`, `fail_seen`, `first_fail`, `pass` and `aborted` at that edge.
- SCAN, each edge:
  - If settle < SETTLE_CYCLES: settle++.
  - Else sample edge:
    - `result_sig[vec]` <= `dut_y`.
    - If `dut_y` != `GOLDEN_SIG[vec]`: `mismatch_cnt`++; if `fail_seen` = 0, set `first_fail` = vec and `fail_seen` = 1.
    - settle = 0.
    - If vec = 15: -> DONE. Else vec++.
- Per-vector hold: each vector is held SETTLE_CYCLES+1 cycles.
  - Last sample occurs at edge k+16*(SETTLE_CYCLES+1).
  - `done` is high in the following cycle (k+48 for the default).
  - With SETTLE_CYCLES = 0, one vector per cycle and `done` follows edge k+16.
- DONE:
  - `done` = 1 for exactly one cycle.
  - `pass` = (`mismatch_cnt` == 0) && !`aborted`, registered on entry.
  - Then -> IDLE unconditionally.
  - vec returns to 0 in IDLE.
- abort:
  - In SCAN, `abort` = 1 at an edge takes priority over the sample at that edge.
  - -> DONE with `aborted` = 1, `pass` = 0.
  - Partial `result_sig`/`mismatch_cnt` are retained.
  - `abort` is ignored in IDLE and DONE.
- `start` while in SCAN or DONE is ignored, with no queuing. `start` held high re-launches from IDLE, so scans run back-to-back with one IDLE cycle between them.
- Simultaneous `rst` and `start`/`abort`: `rst` wins.
- `mismatch_cnt` saturates by construction: at most 16 increments, 5 bits.
- Results hold stable in IDLE until the next accepted `start`.

Decomposition:
- Package `non_hwt_pkg`:
  - state enum (IDLE/SCAN/DONE)
  - NUM_VEC = 16
  - VEC_W = 4
  - CNT_W = 5
  - default GOLDEN_SIG constant 16'hF800
  - golden function `golden_y(vec)` for bench and RTL cross-check
- One natural sub-module: `non_hwt_resp_checker`. It takes vec, `dut_y` and sample_en, and owns the `result_sig`/`mismatch_cnt`/`fail_seen`/`first_fail` registers. The top level keeps the FSM and settle counter.

Test Plan:
- Golden cell model, SETTLE_CYCLES = 2, `start` pulse at edge k -> `dut_*` steps 0..15; `done` one cycle after edge k+48; `result_sig` = 16'hF800, `mismatch_cnt` = 0, `fail_seen` = 0, `pass` = 1.
- `dut_y` stuck-at-0 -> `result_sig` = 16'h0000, `mismatch_cnt` = 5, `first_fail` = 11, `pass` = 0.
- Trojan model (Y inverted only for vector 7) -> `result_sig` = 16'hF880, `mismatch_cnt` = 1, `first_fail` = 7, `fail_seen` = 1, `pass` = 0.
- `abort` asserted during the settle of vector 5 -> `done` next cycle, `aborted` = 1, `pass` = 0, `result_sig` bits 0..4 only, no sample of vector 5.
- `start` re-pulsed mid-scan, then `rst` asserted at vector 9 -> re-pulse has no effect on timing; after `rst` all outputs are 0, state IDLE, and a new `start` yields a clean golden result.
- SETTLE_CYCLES = 0 with `start` held high -> `done` every 18 cycles (16 SCAN + DONE + IDLE); `pass` = 1 each scan.
